// File: rtl/dmc_master.sv
// Command initiator for the dual-memory controller: turns write, read and block-copy commands
// into the mem_select/write_enable/add_ex/data_ex cycle sequence and captures read data.
module dmc_master #(
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic          cmd_sel,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_addr2,
  input  logic [7:0]    cmd_len,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          done,
  output logic          busy,
  output logic          mem_select,
  output logic          write_enable,
  output logic [AW-1:0] add_ex,
  output logic [DW-1:0] data_ex,
  input  logic [DW-1:0] data_in
);

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StCpRd, StCpWr, StFin} state_e;

  localparam logic [2:0] LatLast = 3'(RD_LAT);

  state_e        state_q;
  logic [2:0]    lat_q;
  logic [7:0]    idx_q;
  logic [7:0]    len_q;
  logic          sel_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr2_q;
  logic          ready_q;
  logic          done_q;
  logic          rsp_valid_q;
  logic [DW-1:0] rsp_data_q;
  logic          mem_select_q;
  logic          we_q;
  logic [AW-1:0] add_q;
  logic [DW-1:0] data_q;

  // Outputs for the next state are registered on the transition edge, so every dmc-facing
  // signal is valid for the whole cycle it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      lat_q        <= '0;
      idx_q        <= '0;
      len_q        <= '0;
      sel_q        <= 1'b0;
      addr_q       <= '0;
      addr2_q      <= '0;
      ready_q      <= 1'b0;
      done_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      mem_select_q <= 1'b0;
      we_q         <= 1'b0;
      add_q        <= '0;
      data_q       <= '0;
    end else begin
      done_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          ready_q <= 1'b1;
          if (cmd_valid && ready_q) begin
            ready_q <= 1'b0;
            sel_q   <= cmd_sel;
            addr_q  <= cmd_addr;
            addr2_q <= cmd_addr2;
            len_q   <= cmd_len;
            idx_q   <= '0;
            lat_q   <= '0;
            unique case (cmd_op)
              2'b00: begin
                state_q      <= StWrite;
                we_q         <= 1'b1;
                mem_select_q <= cmd_sel;
                add_q        <= cmd_addr;
                data_q       <= cmd_wdata;
              end
              2'b01: begin
                state_q      <= StRead;
                mem_select_q <= cmd_sel;
                add_q        <= cmd_addr;
              end
              2'b10: begin
                if (cmd_len == 8'd0) begin
                  state_q <= StFin;
                  done_q  <= 1'b1;
                end else begin
                  state_q      <= StCpRd;
                  mem_select_q <= cmd_sel;
                  add_q        <= cmd_addr;
                end
              end
              2'b11: begin
                state_q <= StFin;
                done_q  <= 1'b1;
              end
            endcase
          end
        end
        StWrite: begin
          state_q      <= StFin;
          done_q       <= 1'b1;
          we_q         <= 1'b0;
          mem_select_q <= 1'b0;
          add_q        <= '0;
          data_q       <= '0;
        end
        StRead: begin
          if (lat_q == LatLast) begin
            state_q      <= StFin;
            done_q       <= 1'b1;
            rsp_valid_q  <= 1'b1;
            rsp_data_q   <= data_in;
            lat_q        <= '0;
            mem_select_q <= 1'b0;
            add_q        <= '0;
          end else begin
            lat_q <= lat_q + 3'd1;
          end
        end
        StCpRd: begin
          if (lat_q == LatLast) begin
            state_q      <= StCpWr;
            lat_q        <= '0;
            data_q       <= data_in;
            we_q         <= 1'b1;
            mem_select_q <= ~sel_q;
            add_q        <= addr2_q + AW'(idx_q);
          end else begin
            lat_q <= lat_q + 3'd1;
          end
        end
        StCpWr: begin
          idx_q  <= idx_q + 8'd1;
          we_q   <= 1'b0;
          data_q <= '0;
          if (idx_q + 8'd1 == len_q) begin
            state_q      <= StFin;
            done_q       <= 1'b1;
            mem_select_q <= 1'b0;
            add_q        <= '0;
          end else begin
            state_q      <= StCpRd;
            mem_select_q <= sel_q;
            add_q        <= addr_q + AW'(idx_q + 8'd1);
          end
        end
        StFin: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready    = ready_q;
  assign busy         = ~ready_q;
  assign done         = done_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign mem_select   = mem_select_q;
  assign write_enable = we_q;
  assign add_ex       = add_q;
  assign data_ex      = data_q;

endmodule

// File: tb/tb_dmc_master.sv
// Directed bench for dmc_master with a behavioural two-memory dmc stub (one-edge read latency)
// and a read-data scoreboard.
module tb_dmc_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic       cmd_sel = 1'b0;
  logic [7:0] cmd_addr = '0;
  logic [7:0] cmd_addr2 = '0;
  logic [7:0] cmd_len = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       done;
  logic       busy;
  logic       mem_select;
  logic       write_enable;
  logic [7:0] add_ex;
  logic [7:0] data_ex;
  logic [7:0] data_in = '0;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem_a [0:255] = '{default: 8'h00};
  logic [7:0] mem_b [0:255] = '{default: 8'h00};

  logic [7:0] exp_q [$];
  logic [7:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];
  logic       wr_sel_q [$];
  logic [7:0] rd_addr_q [$];
  int         rsp_k;

  dmc_master #(.AW(8), .DW(8), .RD_LAT(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_sel      (cmd_sel),
    .cmd_addr     (cmd_addr),
    .cmd_addr2    (cmd_addr2),
    .cmd_len      (cmd_len),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .done         (done),
    .busy         (busy),
    .mem_select   (mem_select),
    .write_enable (write_enable),
    .add_ex       (add_ex),
    .data_ex      (data_ex),
    .data_in      (data_in)
  );

  always #5 clk = ~clk;

  // dmc stand-in: synchronous write, read data valid one edge after the address
  always @(posedge clk) begin
    if (write_enable) begin
      if (mem_select) mem_b[add_ex] <= data_ex;
      else            mem_a[add_ex] <= data_ex;
    end
    data_in <= mem_select ? mem_b[add_ex] : mem_a[add_ex];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a command, wait (bounded) for acceptance, and return in the first cycle after it.
  task automatic accept(input logic [1:0] op, input logic sel, input logic [7:0] a,
                        input logic [7:0] a2, input logic [7:0] len, input logic [7:0] wd);
    int w;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_sel   = sel;
    cmd_addr  = a;
    cmd_addr2 = a2;
    cmd_len   = len;
    cmd_wdata = wd;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("accept_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    // Scramble fields so a design that fails to latch them shows it.
    cmd_valid = 1'b0;
    cmd_sel   = ~sel;
    cmd_addr  = ~a;
    cmd_addr2 = ~a2;
    cmd_len   = 8'hFF;
    cmd_wdata = ~wd;
  endtask

  // Observe cycles E+1.. until done; log writes, element read addresses and responses.
  task automatic track(output int done_k);
    logic prev_we;
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_sel_q.delete();
    rd_addr_q.delete();
    rsp_k   = 0;
    done_k  = 0;
    prev_we = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      if (write_enable) begin
        wr_addr_q.push_back(add_ex);
        wr_data_q.push_back(data_ex);
        wr_sel_q.push_back(mem_select);
      end else if (!done && prev_we) begin
        rd_addr_q.push_back(add_ex);
      end
      prev_we = write_enable;
      if (rsp_valid) begin
        rsp_k = k;
        if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
        else check("rsp_data", 32'(rsp_data), 32'(exp_q.pop_front()));
      end
      if (done) begin
        done_k = k;
        break;
      end
      @(negedge clk);
    end
    check("done_seen", 32'(done_k != 0), 32'd1);
    @(negedge clk);
    check("ready_after_fin", 32'(cmd_ready), 32'd1);
  endtask

  task automatic do_write(input logic sel, input logic [7:0] a, input logic [7:0] d);
    int dk;
    accept(2'b00, sel, a, 8'h00, 8'h00, d);
    track(dk);
    check("wr_done_lat", 32'(dk), 32'd2);
    check("wr_count", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() == 1) begin
      check("wr_addr", 32'(wr_addr_q[0]), 32'(a));
      check("wr_data", 32'(wr_data_q[0]), 32'(d));
      check("wr_sel", 32'(wr_sel_q[0]), 32'(sel));
    end
  endtask

  task automatic do_read(input logic sel, input logic [7:0] a, input logic [7:0] exp);
    int dk;
    exp_q.push_back(exp);
    accept(2'b01, sel, a, 8'h00, 8'h00, 8'h00);
    track(dk);
    check("rd_done_lat", 32'(dk), 32'd3);
    check("rd_rsp_lat", 32'(rsp_k), 32'd3);
    check("rd_no_write", 32'(wr_addr_q.size()), 32'd0);
  endtask

  initial begin
    int dk;
    int nwe;
    int saw_done;
    logic [7:0] src_exp [4];
    logic [7:0] val_exp [4];

    // 1. reset hold
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("reset_outputs",
            32'({write_enable, mem_select, add_ex, data_ex, done, rsp_valid, rsp_data,
                 cmd_ready, busy}), 32'd1);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", 32'(cmd_ready), 32'd1);
    check("busy_after_release", 32'(busy), 32'd0);

    // 2. memory A write then read
    do_write(1'b0, 8'h02, 8'h0A);
    do_read(1'b0, 8'h02, 8'h0A);

    // 3. memory B write then read; A at same address untouched
    do_write(1'b1, 8'h03, 8'h0B);
    do_read(1'b1, 8'h03, 8'h0B);
    do_read(1'b0, 8'h03, 8'h00);

    // 4. copy with source address wrap
    do_write(1'b0, 8'hFE, 8'h11);
    do_write(1'b0, 8'hFF, 8'h22);
    do_write(1'b0, 8'h00, 8'h33);
    do_write(1'b0, 8'h01, 8'h44);
    src_exp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    val_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    accept(2'b10, 1'b0, 8'hFE, 8'h10, 8'd4, 8'h00);
    track(dk);
    check("cp_done_lat", 32'(dk), 32'd13);
    check("cp_wr_count", 32'(wr_addr_q.size()), 32'd4);
    check("cp_rd_count", 32'(rd_addr_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < wr_addr_q.size()) begin
        check("cp_wr_addr", 32'(wr_addr_q[i]), 32'(8'h10 + 8'(i)));
        check("cp_wr_data", 32'(wr_data_q[i]), 32'(val_exp[i]));
        check("cp_wr_sel", 32'(wr_sel_q[i]), 32'd1);
      end
      if (i < rd_addr_q.size()) check("cp_src_addr", 32'(rd_addr_q[i]), 32'(src_exp[i]));
    end
    for (int i = 0; i < 4; i++) do_read(1'b1, 8'h10 + 8'(i), val_exp[i]);

    // 5. degenerate commands
    accept(2'b10, 1'b0, 8'h05, 8'h50, 8'd0, 8'h00);
    track(dk);
    check("cp0_done_lat", 32'(dk), 32'd1);
    check("cp0_no_write", 32'(wr_addr_q.size()), 32'd0);
    accept(2'b11, 1'b1, 8'h06, 8'h60, 8'd3, 8'h99);
    track(dk);
    check("nop_done_lat", 32'(dk), 32'd1);
    check("nop_no_write", 32'(wr_addr_q.size()), 32'd0);

    // 6. reset during the second copy write
    do_write(1'b0, 8'h40, 8'h55);
    do_write(1'b0, 8'h41, 8'h66);
    accept(2'b10, 1'b0, 8'h40, 8'h20, 8'd4, 8'h00);
    nwe = 0;
    saw_done = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) saw_done = 1;
      if (write_enable) nwe++;
      if (nwe == 2) break;
      @(negedge clk);
    end
    check("rst_second_write_seen", 32'(nwe), 32'd2);
    rst_n = 1'b0;
    #1;
    check("rst_we_drop", 32'(write_enable), 32'd0);
    check("rst_no_done_before", 32'(saw_done), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rst_quiet", 32'({done, rsp_valid, write_enable, cmd_ready}), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready_after", 32'(cmd_ready), 32'd1);
    check("rst_elem0_written", 32'(mem_b[8'h20]), 32'h55);
    check("rst_elem1_not_written", 32'(mem_b[8'h21]), 32'h00);
    do_write(1'b1, 8'h21, 8'h77);
    do_read(1'b1, 8'h21, 8'h77);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
